// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Operand and result handshakes of the bit-serial subtractor.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             borrow_in_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] diff_o;
    logic             borrow_o;

    // Producer and consumer side.
    modport master (
        output in_valid_i, a_i, b_i, borrow_in_i, out_ready_i,
        input  in_ready_o, out_valid_o, diff_o, borrow_o
    );

    // Subtractor side.
    modport slave (
        input  in_valid_i, a_i, b_i, borrow_in_i, out_ready_i,
        output in_ready_o, out_valid_o, diff_o, borrow_o
    );
endinterface

// File: rtl/subtractor.sv
// 1-bit full subtractor cell: diff and borrow of a - b - c.
module subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic borrow_o,
    output logic diff_o
);
    assign diff_o   = a_i ^ b_i ^ c_i;
    assign borrow_o = (~a_i & (b_i | c_i)) | (b_i & c_i);
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one bit pair per clock, LSB first,
// borrow carried between bits in a register.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    serial_subtractor_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("serial_subtractor_ctrl: WIDTH must be within 2..%0d", MAX_WIDTH);
        end
    endgenerate

    sub_state_t       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             brw;
    logic [CNT_W-1:0] bit_cnt;
    logic             cell_diff;
    logic             cell_borrow;

    subtractor u_cell (
        .a_i      (a_sh[0]),
        .b_i      (b_sh[0]),
        .c_i      (brw),
        .borrow_o (cell_borrow),
        .diff_o   (cell_diff)
    );

    // NOTE: every register here uses <= so all updates in a state see the
    // pre-edge values (e.g. the result captured in the last RUN cycle uses
    // the old res_sh, not the one being shifted on the same edge).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= IDLE;
            bus.in_ready_o  <= 1'b1;
            bus.out_valid_o <= 1'b0;
            bus.diff_o      <= '0;
            bus.borrow_o    <= 1'b0;
            a_sh            <= '0;
            b_sh            <= '0;
            res_sh          <= '0;
            brw             <= 1'b0;
            bit_cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        a_sh           <= bus.a_i;
                        b_sh           <= bus.b_i;
                        brw            <= bus.borrow_in_i;
                        bit_cnt        <= '0;
                        bus.in_ready_o <= 1'b0;
                        state          <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_sh  <= {cell_diff, res_sh[WIDTH-1:1]};
                    brw     <= cell_borrow;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        // Present the completed word directly from this edge.
                        bus.diff_o      <= {cell_diff, res_sh[WIDTH-1:1]};
                        bus.borrow_o    <= cell_borrow;
                        bus.out_valid_o <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        bus.out_valid_o <= 1'b0;
                        bus.in_ready_o  <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state           <= IDLE;
                    bus.in_ready_o  <= 1'b1;
                    bus.out_valid_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
